// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that shares one synchronous FIFO write
// port among NREQ producers. One requester owns the port at a time and may
// stream up to BURST words before the grant is released. The block stores no
// data. A word moves from the owning requester to the FIFO in the same cycle
// it is acknowledged.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req         per-requester write request (held with stable data until acked)
//   din         flattened requester data, requester i at [i*WIDTH +: WIDTH]
//   ack         one-hot write acknowledge to the owning requester
//   fifo_full   FIFO full flag
//   fifo_wen    FIFO write enable
//   fifo_wdata  FIFO write data (zero when fifo_wen is low)
//   gnt_vld     a requester currently owns the port
//   gnt_id      index of the current owner (zero when gnt_vld is low)
//
// State    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no owner; pick the next requester after r_last, never writes
// S_GRANT  | r_owner owns the port; writes while requesting and not full

module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic                  gnt_vld,
    output logic [IDW-1:0]        gnt_id
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  r_last;
    logic [CW-1:0]   r_cnt;

    logic            w_any_req;
    logic [IDW-1:0]  w_pick;
    logic            w_own_req;
    logic            w_wr;
    logic            w_last_beat;

    // Round-robin search from r_last+1 upward with wrap. The loop runs from
    // the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        w_pick = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(r_last) + k) % NREQ]) begin
                w_pick = IDW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_any_req   = |req;
    assign w_own_req   = req[r_owner];
    assign w_wr        = (r_state == S_GRANT) && w_own_req && !fifo_full;
    assign w_last_beat = (r_cnt == CW'(BURST - 1));

    assign fifo_wen   = w_wr;
    assign fifo_wdata = w_wr ? din[int'(r_owner)*WIDTH +: WIDTH] : '0;
    assign ack        = w_wr ? (NREQ'(1) << r_owner) : '0;
    assign gnt_vld    = (r_state == S_GRANT);
    assign gnt_id     = (r_state == S_GRANT) ? r_owner : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            // Requester 0 gets first priority out of reset.
            r_last  <= IDW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_own_req) begin
                        // Owner withdrew: release without writing.
                        r_last  <= r_owner;
                        r_state <= S_IDLE;
                    end else if (!fifo_full) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last_beat) begin
                            r_last  <= r_owner;
                            r_state <= S_IDLE;
                        end
                    end
                    // Full with request held: stall, grant and count hold.
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (NREQ=4, WIDTH=8, BURST=4). Inputs change
// 1 time unit after the rising edge and outputs are sampled on the falling
// edge, so each "cycle" below is one clock period from drive to sample.

module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic                  fifo_full;
    logic                  fifo_wen;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  gnt_vld;
    logic [IDW-1:0]        gnt_id;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arb #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .BURST(BURST),
        .IDW  (IDW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_wdata(fifo_wdata),
        .gnt_vld   (gnt_vld),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_vld, input logic [IDW-1:0] e_id,
                           input logic [NREQ-1:0] e_ack, input logic e_wen,
                           input logic [WIDTH-1:0] e_wdata);
        chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e_vld));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".wen"}, 32'(fifo_wen), 32'(e_wen));
        chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(e_wdata));
    endtask

    // Leaves the bench 1 unit after a rising edge with reset released.
    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0]  t1_ack;
        logic [9:0]  t1_vld;
        logic [8:0]  t3_full;
        logic [8:0]  t3_wen;
        logic [8:0]  t3_vld;
        int          w;
        int          own;

        rst       = 1'b0;
        req       = '0;
        din       = '0;
        fifo_full = 1'b0;
        #2;
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);

        // 1: single requester, 6 words, BURST=4 -> acks cycles 1-4 and 6-7.
        do_reset();
        t1_ack = 10'b0011011110;
        t1_vld = 10'b0111011110;
        w = 0;
        for (int c = 0; c < 10; c++) begin
            req[0]  = (w < 6);
            din[7:0] = 8'hA0 + 8'(w);
            @(negedge clk);
            chk_out($sformatf("t1.c%0d", c), t1_vld[c], 2'd0,
                    {3'b000, t1_ack[c]}, t1_ack[c], t1_ack[c] ? 8'hA0 + 8'(w) : 8'h00);
            if (t1_ack[c]) w++;
            next_cycle();
        end
        chk("t1.words", 32'(w), 32'd6);

        // 2: all requesting -> owners 0,1,2,3,0 in bursts of 4 split by one idle.
        do_reset();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c % 5 == 0) begin
                chk_out($sformatf("t2.c%0d", c), 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
            end else begin
                own = ((c - 1) / 5) % 4;
                chk_out($sformatf("t2.c%0d", c), 1'b1, IDW'(own), 4'(1 << own), 1'b1,
                        8'(8'h11 * (own + 1)));
            end
            next_cycle();
        end

        // 3: requester 2 stalls 3 cycles on full after 2 writes, then 2 more.
        do_reset();
        t3_full = 9'b000111000;
        t3_wen  = 9'b011000110;
        t3_vld  = 9'b011111110;
        w = 0;
        for (int c = 0; c < 9; c++) begin
            req         = 4'b0100;
            fifo_full   = t3_full[c];
            din[23:16]  = 8'hC0 + 8'(w);
            @(negedge clk);
            chk_out($sformatf("t3.c%0d", c), t3_vld[c], t3_vld[c] ? 2'd2 : 2'd0,
                    t3_wen[c] ? 4'b0100 : 4'b0000, t3_wen[c],
                    t3_wen[c] ? 8'hC0 + 8'(w) : 8'h00);
            if (t3_wen[c]) w++;
            next_cycle();
        end
        chk("t3.words", 32'(w), 32'd4);
        fifo_full = 1'b0;

        // 4: owner 0 drops after 1 write; release, idle, then requester 1.
        do_reset();
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0011;
        @(negedge clk);
        chk_out("t4.c0", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t4.c1", 1'b1, 2'd0, 4'b0001, 1'b1, 8'h11);
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        chk_out("t4.c2", 1'b1, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t4.c3", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t4.c4", 1'b1, 2'd1, 4'b0010, 1'b1, 8'h22);
        next_cycle();

        // 5: last=2, req[1] and req[3] together -> 3 first, then 1.
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        chk_out("t5.rel2", 1'b1, 2'd2, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        req = 4'b1010;
        @(negedge clk);
        chk_out("t5.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t5.g3", 1'b1, 2'd3, 4'b1000, 1'b1, 8'h44);
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        chk_out("t5.rel3", 1'b1, 2'd3, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t5.idle2", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t5.g1", 1'b1, 2'd1, 4'b0010, 1'b1, 8'h22);
        next_cycle();

        // 6: reset mid-burst clears outputs before the next edge.
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_out("t6.pre", 1'b1, 2'd0, 4'b0001, 1'b1, 8'h11);
        #1 rst = 1'b0;
        #1;
        chk_out("t6.async", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        req = 4'b1010;
        @(negedge clk);
        chk_out("t6.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00);
        next_cycle();
        @(negedge clk);
        chk_out("t6.g1", 1'b1, 2'd1, 4'b0010, 1'b1, 8'h22);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO write port among `NREQ` producers. It sits directly in front of the FIFO. It grants the write port to one requester at a time, lets that requester stream up to `BURST` words, and drives the FIFO's `wen`/`wdata` inputs while honouring the FIFO `full` flag. The arbiter stores no data; words pass from the owning requester to the FIFO in the same cycle they are acknowledged.

## Interface
- `NREQ`, default 4: number of requesters; ≥2.
- `WIDTH`, default 8: data word width; matches the FIFO `width`.
- `BURST`, default 4: maximum words written per grant; ≥1.
- `IDW`, default `$clog2(NREQ)`: width of the grant index.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: per-requester write request. Held high with stable data until acked.
- `din` in `NREQ*WIDTH`: flattened requester data; requester i occupies `[i*WIDTH +: WIDTH]`.
- `ack` out `NREQ`: one-hot. `ack[i]` high means requester i's word is written at this clock edge.
- `fifo_full` in 1: FIFO full flag.
- `fifo_wen` out 1: FIFO write enable.
- `fifo_wdata` out `WIDTH`: FIFO write data.
- `gnt_vld` out 1: a requester currently owns the port.
- `gnt_id` out `IDW`: index of the current owner; valid when `gnt_vld` is high.

## Operation
- Two states: IDLE and GRANT. Registered state consists of `state`, `owner[IDW]`, `last[IDW]` and `cnt` (width `$clog2(BURST+1)`).
- **IDLE:** if any `req` bit is set, pick the first set bit searching upward from `last+1` with wrap modulo `NREQ`. Load `owner` with that index, clear `cnt`, go to GRANT. No write occurs in IDLE.
- **GRANT, write cycle:** when `req[owner] && !fifo_full`, the block drives `fifo_wen=1`, `fifo_wdata=din[owner]` and `ack[owner]=1`, and increments `cnt`.
- **GRANT, stall:** when `req[owner] && fifo_full`, there is no write and no ack. `cnt` holds and the grant holds with no timeout.
- **GRANT, release:** the grant is released (to IDLE, `last<=owner`) when either:
  - `req[owner]` is low; no write occurs that cycle, or
  - a write occurs with `cnt==BURST-1`; that is the final beat.
- All of `fifo_wen`, `fifo_wdata` and `ack` are combinational from registered state plus `req`/`fifo_full`. There is no other combinational path.
- `fifo_wdata` is 0 whenever `fifo_wen` is 0.
- `ack` is never asserted for a non-owner. At most one `ack` bit is high.
- A requester dropping `req` without an ack is legal; its word is simply not written.

## Timing
- **Reset (`rst` low, asynchronous):**
  - State values: `state`=IDLE, `owner`=0, `last`=`NREQ-1` (so requester 0 has first priority), `cnt`=0.
  - Outputs: `gnt_vld`=0, `gnt_id`=0, `ack`=0, `fifo_wen`=0, `fifo_wdata`=0.
  - Reset asserted mid-burst drops the grant immediately. Words already acked are in the FIFO; the in-flight beat is not written.
- **Grant latency:** `req` rising in IDLE during cycle t gives `gnt_vld` high from edge t+1. The first write/ack can occur in cycle t+1.
- **Burst throughput:** a burst of `BURST` writes is followed by one mandatory IDLE cycle, giving a peak rate of `BURST/(BURST+1)` words per cycle.
- **`fifo_full`:** sampled in the same cycle as the write decision. The FIFO's own full guard is redundant but harmless.
- **Re-grant after a burst:** a requester still requesting competes again in IDLE. It wins only if no other requester sits between it and itself in round-robin order.

## Test plan
1. **Single requester:** `NREQ=4`, `BURST=4`. Only `req[0]` is held for 6 words with FIFO not full. Required: acks in cycles 1–4, IDLE in cycle 5, acks in cycles 6–7. `gnt_id`=0 throughout, and the FIFO receives all 6 words in order.
2. **All requesters continuous:** `req=4'b1111` continuously. Required: `gnt_id` sequence 0,1,2,3,0. `fifo_wen` pattern is 4 high, 1 low, repeating, and each grant yields exactly 4 acks.
3. **Stall on full:** requester 2 owns the port and `fifo_full` rises after 2 writes for 3 cycles. Required: during the stall `fifo_wen=0`, `ack=0`, and `gnt_id` stays 2. After the stall, 2 more writes occur, then release.
4. **Early drop:** the owner drops `req` after 1 write. Required: release that cycle with no write, IDLE for one cycle, then the next requester in rotation is granted.
5. **Priority wrap:** `last`=2 and `req[1]` and `req[3]` rise simultaneously. Required: 3 is granted first, then 1.
6. **Reset mid-burst:** `rst` is pulled low mid-burst. Required: all outputs go to 0 asynchronously, before the next edge. After release, with `req=4'b1010`, requester 1 is granted first.
